// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, constants and mode decode for the SPI slave
// Contents:
//   SPI_WORD_W / SPI_CNT_W : byte width and bit-counter width
//   spi_slave_state_e      : IDLE / LOAD / XFER frame states
//   spi_edge_sel_t         : which SCLK direction samples and which shifts
//   spi_mode_edges()       : decodes cpol/cpha into an spi_edge_sel_t
package spi_pkg;

    localparam int SPI_WORD_W = 8;
    localparam int SPI_CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2
    } spi_slave_state_e;

    typedef struct packed {
        logic sample_rise;  // 1: sample MOSI on SCLK rising, 0: on falling
        logic shift_rise;   // 1: advance MISO on SCLK rising, 0: on falling
    } spi_edge_sel_t;

    // The leading edge is a rise when cpol=0. cpha=0 samples on the leading
    // edge, so sampling happens on a rise exactly when cpol == cpha.
    function automatic spi_edge_sel_t spi_mode_edges(input logic cpol, input logic cpha);
        spi_edge_sel_t sel;
        sel.sample_rise = ~(cpol ^ cpha);
        sel.shift_rise  = cpol ^ cpha;
        return sel;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - N-flop synchronizer for one asynchronous input bit
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset, clears every stage to 0
//   d_i   : asynchronous input
//   q_o   : synchronized output, STAGES cycles behind d_i
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // The cast drops the oldest stage, which also keeps STAGES=1 legal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= STAGES'({sync_q, d_i});
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled byte-oriented SPI slave, all four CPOL/CPHA modes
// Ports:
//   clk, reset : system clock, asynchronous active-low reset
//   cpol, cpha : SPI mode, static while SS is low
//   tx_data    : byte returned on MISO, captured at each byte start
//   rx_data    : last complete received byte
//   done       : one-cycle strobe when rx_data updates
//   busy       : frame active
//   SCLK, MOSI, SS : SPI pins from the master (SS active low)
//   MISO       : serial data out, 0 while not selected
module spi_slave
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [SPI_WORD_W-1:0] tx_data,
    output logic [SPI_WORD_W-1:0] rx_data,
    output logic                  done,
    output logic                  busy,
    input  logic                  SCLK,
    input  logic                  MOSI,
    input  logic                  SS,
    output logic                  MISO
);

    logic sclk_s, mosi_s, ss_s;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (.clk(clk), .rst_n(reset), .d_i(SCLK), .q_o(sclk_s));
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clk(clk), .rst_n(reset), .d_i(MOSI), .q_o(mosi_s));
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ss   (.clk(clk), .rst_n(reset), .d_i(SS),   .q_o(ss_s));

    spi_slave_state_e      state_q;
    logic                  sclk_prev_q;
    logic                  ss_prev_q;
    logic [SPI_WORD_W-1:0] tx_shift_q;
    logic [SPI_WORD_W-1:0] rx_shift_q;
    logic [SPI_WORD_W-1:0] rx_shift_d;
    logic [SPI_CNT_W-1:0]  bit_cnt_q;
    logic [SPI_WORD_W-1:0] rx_data_q;
    logic                  done_q;
    logic                  busy_q;
    logic                  miso_q;

    spi_edge_sel_t edge_sel;
    logic          sclk_rise, sclk_fall;
    logic          sample_edge, shift_edge;
    logic          ss_fall;

    assign edge_sel    = spi_mode_edges(cpol, cpha);
    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;
    assign sample_edge = edge_sel.sample_rise ? sclk_rise : sclk_fall;
    assign shift_edge  = edge_sel.shift_rise  ? sclk_rise : sclk_fall;
    // ss_prev_q resets to 0, so an SS already low when reset releases never
    // looks like a fall; a new frame needs SS to go high first.
    assign ss_fall     = ss_prev_q & ~ss_s;
    assign rx_shift_d  = {rx_shift_q[SPI_WORD_W-2:0], mosi_s};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            rx_data_q   <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (ss_fall) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ss_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        miso_q  <= 1'b0;
                    end else begin
                        tx_shift_q <= tx_data;
                        bit_cnt_q  <= '0;
                        // Drive MISO straight from tx_data so the first bit
                        // is not a further cycle behind the capture.
                        miso_q     <= tx_data[SPI_WORD_W-1];
                        state_q    <= XFER;
                    end
                end
                XFER: begin
                    if (ss_s) begin
                        // Abort wins over a coincident sample edge.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        miso_q  <= 1'b0;
                    end else begin
                        miso_q <= tx_shift_q[SPI_WORD_W-1];
                        if (sample_edge) begin
                            if (bit_cnt_q == SPI_CNT_W'(SPI_WORD_W - 1)) begin
                                rx_data_q  <= rx_shift_d;
                                rx_shift_q <= rx_shift_d;
                                done_q     <= 1'b1;
                                bit_cnt_q  <= '0;
                                tx_shift_q <= tx_data;
                            end else begin
                                rx_shift_q <= rx_shift_d;
                                bit_cnt_q  <= bit_cnt_q + 1'b1;
                            end
                        end else if (shift_edge && (bit_cnt_q != '0)) begin
                            // bit_cnt == 0 marks either the first leading edge
                            // (cpha=1) or the trailing edge after bit 7
                            // (cpha=0); both must keep the freshly loaded MSB.
                            tx_shift_q <= {tx_shift_q[SPI_WORD_W-2:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    miso_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data = rx_data_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign MISO    = miso_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed self-checking bench for spi_slave
module tb_spi_slave;

    localparam int HALF = 8;  // clk cycles per SCLK half period

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       done;
    logic       busy;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       ss = 1'b1;
    logic       miso;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [7:0] done_log [0:15];

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(rst_n), .cpol(cpol), .cpha(cpha),
        .tx_data(tx_data), .rx_data(rx_data), .done(done), .busy(busy),
        .SCLK(sclk), .MOSI(mosi), .SS(ss), .MISO(miso)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) begin
            if (done_cnt < 16) done_log[done_cnt] = rx_data;
            done_cnt = done_cnt + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha) begin
                mosi = mo[i];
                wait_clk(HALF);
                mi = {mi[6:0], miso};
                sclk = ~cpol;
                wait_clk(HALF);
                sclk = cpol;
            end else begin
                wait_clk(HALF);
                sclk = ~cpol;
                mosi = mo[i];
                wait_clk(HALF);
                mi = {mi[6:0], miso};
                sclk = cpol;
            end
        end
        wait_clk(HALF);
    endtask

    task automatic set_mode(input logic pol, input logic pha);
        cpol = pol;
        cpha = pha;
        sclk = pol;
        wait_clk(8);
    endtask

    task automatic run_frame(input logic [7:0] mo, input logic [7:0] tx, output logic [7:0] mi);
        tx_data = tx;
        wait_clk(4);
        ss = 1'b0;
        wait_clk(8);
        xfer_bits(mo, 8, mi);
        ss = 1'b1;
        wait_clk(12);
    endtask

    typedef struct {
        logic       pol;
        logic       pha;
        logic [7:0] mo;
        logic [7:0] tx;
        logic [7:0] exp_rx;
        logic [7:0] exp_mi;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [7:0] mi, mi0, mi1;
        int d0;

        vecs[0] = '{1'b0, 1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{1'b0, 1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
        vecs[2] = '{1'b1, 1'b0, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
        vecs[3] = '{1'b1, 1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[5] = '{1'b1, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};

        // Reset state
        wait_clk(5);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_done", 32'(done), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_miso", 32'(miso), 32'h0);
        rst_n = 1'b1;
        wait_clk(8);

        // Single-byte frames in every mode
        for (int v = 0; v < 6; v++) begin
            set_mode(vecs[v].pol, vecs[v].pha);
            d0 = done_cnt;
            run_frame(vecs[v].mo, vecs[v].tx, mi);
            check($sformatf("vec%0d_rx_data", v), 32'(rx_data), 32'(vecs[v].exp_rx));
            check($sformatf("vec%0d_done_count", v), 32'(done_cnt - d0), 32'd1);
            check($sformatf("vec%0d_master_rx", v), 32'(mi), 32'(vecs[v].exp_mi));
            check($sformatf("vec%0d_busy_after", v), 32'(busy), 32'h0);
            check($sformatf("vec%0d_miso_after", v), 32'(miso), 32'h0);
        end

        // Two bytes in one frame, tx_data changed after the first capture
        set_mode(1'b0, 1'b0);
        d0 = done_cnt;
        tx_data = 8'h80;
        wait_clk(4);
        ss = 1'b0;
        wait_clk(8);
        check("multi_busy_during", 32'(busy), 32'h1);
        tx_data = 8'h01;
        xfer_bits(8'h11, 8, mi0);
        xfer_bits(8'h22, 8, mi1);
        ss = 1'b1;
        wait_clk(12);
        check("multi_done_count", 32'(done_cnt - d0), 32'd2);
        check("multi_rx_byte0", 32'(done_log[d0]), 32'h11);
        check("multi_rx_byte1", 32'(done_log[d0 + 1]), 32'h22);
        check("multi_master_byte0", 32'(mi0), 32'h80);
        check("multi_master_byte1", 32'(mi1), 32'h01);

        // Abort after 5 bits of 0xFF
        d0 = done_cnt;
        tx_data = 8'hFF;
        wait_clk(4);
        ss = 1'b0;
        wait_clk(8);
        xfer_bits(8'hFF, 5, mi);
        ss = 1'b1;
        wait_clk(12);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_rx_kept", 32'(rx_data), 32'h22);
        check("abort_miso", 32'(miso), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        d0 = done_cnt;
        run_frame(8'h96, 8'h69, mi);
        check("post_abort_rx", 32'(rx_data), 32'h96);
        check("post_abort_done", 32'(done_cnt - d0), 32'd1);
        check("post_abort_master_rx", 32'(mi), 32'h69);

        // Reset pulsed mid-byte while SS stays low
        d0 = done_cnt;
        tx_data = 8'hFF;
        wait_clk(4);
        ss = 1'b0;
        wait_clk(8);
        xfer_bits(8'hF0, 4, mi);
        rst_n = 1'b0;
        #1;
        check("midreset_rx_data", 32'(rx_data), 32'h00);
        check("midreset_done", 32'(done), 32'h0);
        check("midreset_busy", 32'(busy), 32'h0);
        check("midreset_miso", 32'(miso), 32'h0);
        wait_clk(3);
        rst_n = 1'b1;
        xfer_bits(8'h0F, 8, mi);
        check("after_reset_no_done", 32'(done_cnt - d0), 32'd0);
        check("after_reset_busy", 32'(busy), 32'h0);
        ss = 1'b1;
        wait_clk(12);
        d0 = done_cnt;
        run_frame(8'h3C, 8'hA5, mi);
        check("after_reset_rx", 32'(rx_data), 32'h3C);
        check("after_reset_done", 32'(done_cnt - d0), 32'd1);
        check("after_reset_master_rx", 32'(mi), 32'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
